neuron_memory: RTL and testbench

Neuron value store at the responder end of the neuron memory bus. It services the read address, write address, write data and write enable lines after the internal/external bus selection. It provides synchronous reads with one-cycle latency and single-cycle writes. A built-in clear sequencer zeroes the whole array after reset or on request. The block sits directly downstream of the bus selection logic and feeds the neuron compute datapath and the external host read-back path.

---
 rtl/neuron_pkg.sv | 20 ++
 rtl/neuron_mem_array.sv | 55 +++++
 rtl/neuron_memory.sv | 140 ++++++++++++++
 tb/tb_neuron_memory.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron memory path. The bus selection block, the
// neuron compute datapath and the neuron value store all take their address
// and data widths from here, so changing a width happens in one place.
//   ADDR_WIDTH          : default neuron address width (DEPTH = 2**ADDR_WIDTH)
//   DATA_WIDTH          : default neuron value width
//   neuron_mem_state_t  : store controller states (CLEAR, IDLE)
// ---------------------------------------------------------------------------
package neuron_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } neuron_mem_state_t;

endpackage

// File: rtl/neuron_mem_array.sv
// ---------------------------------------------------------------------------
// neuron_mem_array
// Plain one-write / one-read synchronous storage array with no reset. A read
// that hits the address being written in the same cycle returns the new data
// (write-first), so the caller never sees stale data for a same-cycle update.
// Ports:
//   clk              : clock, all activity on the rising edge
//   write_enable_i   : store write_data_i at write_address_i this edge
//   write_address_i  : write address
//   write_data_i     : write data
//   read_enable_i    : load read_data_o this edge; otherwise it holds
//   read_address_i   : read address
//   read_data_o      : registered read data
// ---------------------------------------------------------------------------
module neuron_mem_array #(
  parameter int ADDR_WIDTH = neuron_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = neuron_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  write_enable_i,
  input  logic [ADDR_WIDTH-1:0] write_address_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  read_enable_i,
  input  logic [ADDR_WIDTH-1:0] read_address_i,
  output logic [DATA_WIDTH-1:0] read_data_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] readData_q;

  // Storage update. No reset on purpose: the owner zeroes the contents with
  // its own clear sequence, which keeps this mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (write_enable_i) begin
      mem_q[write_address_i] <= write_data_i;
    end
  end

  // Registered read port. The bypass forwards same-cycle write data so a
  // read and write to one address behave as write-then-read.
  always_ff @(posedge clk) begin
    if (read_enable_i) begin
      if (write_enable_i && (write_address_i == read_address_i)) begin
        readData_q <= write_data_i;
      end else begin
        readData_q <= mem_q[read_address_i];
      end
    end
  end

  assign read_data_o = readData_q;

endmodule

// File: rtl/neuron_memory.sv
// ---------------------------------------------------------------------------
// neuron_memory
// Neuron value store at the responder end of the neuron memory bus. Serves
// one-cycle-latency reads and single-cycle writes, and runs a clear sequence
// that zeroes every location after reset or when asked to. While clearing,
// bus accesses are ignored and clear_busy is high.
// Ports:
//   clk                   : clock
//   rst_n                 : synchronous active-low reset
//   neuron_read_address   : read address, sampled every edge
//   neuron_write_address  : write address
//   neuron_write_data     : write data
//   neuron_write_enable   : write strobe, one write per high cycle
//   clear_request         : start a full clear (only honoured in IDLE)
//   neuron_read_data      : registered read data
//   neuron_read_valid     : read data matches the address of the previous edge
//   clear_busy            : clear sequence in progress
// ---------------------------------------------------------------------------
module neuron_memory #(
  parameter int ADDR_WIDTH = neuron_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = neuron_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] neuron_read_address,
  input  logic [ADDR_WIDTH-1:0] neuron_write_address,
  input  logic [DATA_WIDTH-1:0] neuron_write_data,
  input  logic                  neuron_write_enable,
  input  logic                  clear_request,
  output logic [DATA_WIDTH-1:0] neuron_read_data,
  output logic                  neuron_read_valid,
  output logic                  clear_busy
);

  import neuron_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  neuron_mem_state_t     state_q, state_d;
  logic [ADDR_WIDTH-1:0] clrAddr_q, clrAddr_d;
  logic                  readValid_q, readValid_d;
  logic                  dataZero_q, dataZero_d;

  logic                  memWriteEnable;
  logic [ADDR_WIDTH-1:0] memWriteAddress;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic                  memReadEnable;
  logic [DATA_WIDTH-1:0] memReadData;

  // State register. dataZero_q stands in for a reset on the array's read
  // register: it forces the read data to zero from reset until the first
  // real read lands, so the array itself can stay reset-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clrAddr_q   <= '0;
      readValid_q <= 1'b0;
      dataZero_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      clrAddr_q   <= clrAddr_d;
      readValid_q <= readValid_d;
      dataZero_q  <= dataZero_d;
    end
  end

  // Next-state logic. The clear pointer walks every address once and wraps
  // to zero on its own as the last location is written. A read is performed
  // on every IDLE edge, including the one that launches a new clear.
  always_comb begin
    state_d     = state_q;
    clrAddr_d   = clrAddr_q;
    readValid_d = (state_q == IDLE);
    dataZero_d  = dataZero_q && (state_q != IDLE);
    case (state_q)
      CLEAR: begin
        clrAddr_d = clrAddr_q + ADDR_WIDTH'(1);
        if (clrAddr_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        clrAddr_d = '0;
        if (clear_request) begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Array port control. During CLEAR the write port belongs to the clear
  // sequencer and reads are frozen so the last read data is held. In IDLE a
  // clear request drops any bus write in the same cycle. Nothing touches the
  // array on a reset edge.
  always_comb begin
    memWriteEnable  = 1'b0;
    memWriteAddress = clrAddr_q;
    memWriteData    = '0;
    memReadEnable   = 1'b0;
    case (state_q)
      CLEAR: begin
        memWriteEnable = 1'b1;
      end
      IDLE: begin
        memWriteEnable  = neuron_write_enable && !clear_request;
        memWriteAddress = neuron_write_address;
        memWriteData    = neuron_write_data;
        memReadEnable   = 1'b1;
      end
      default: begin
        memWriteEnable = 1'b0;
      end
    endcase
    if (!rst_n) begin
      memWriteEnable = 1'b0;
      memReadEnable  = 1'b0;
    end
  end

  neuron_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk             (clk),
    .write_enable_i  (memWriteEnable),
    .write_address_i (memWriteAddress),
    .write_data_i    (memWriteData),
    .read_enable_i   (memReadEnable),
    .read_address_i  (neuron_read_address),
    .read_data_o     (memReadData)
  );

  assign neuron_read_data  = dataZero_q ? '0 : memReadData;
  assign neuron_read_valid = readValid_q;
  assign clear_busy        = (state_q == CLEAR);

endmodule

// File: tb/tb_neuron_memory.sv
// ---------------------------------------------------------------------------
// tb_neuron_memory
// Directed bench for neuron_memory. A behavioural model tracks the neuron
// array, the clear countdown and the expected read result; every cycle the
// DUT outputs are compared against it, and hand-computed values pin the
// model at the interesting points.
// ---------------------------------------------------------------------------
module tb_neuron_memory;

  localparam int DEPTH = 256;

  logic       clk;
  logic       rst_n;
  logic [7:0] neuron_read_address;
  logic [7:0] neuron_write_address;
  logic [7:0] neuron_write_data;
  logic       neuron_write_enable;
  logic       clear_request;
  logic [7:0] neuron_read_data;
  logic       neuron_read_valid;
  logic       clear_busy;

  int checks;
  int errors;

  // Model state
  logic [7:0] mMem [DEPTH];
  logic [7:0] mData;
  logic       mValid;
  logic       mBusy;
  int         mLeft;
  logic       modelKnown;

  neuron_memory dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .neuron_read_address  (neuron_read_address),
    .neuron_write_address (neuron_write_address),
    .neuron_write_data    (neuron_write_data),
    .neuron_write_enable  (neuron_write_enable),
    .clear_request        (clear_request),
    .neuron_read_data     (neuron_read_data),
    .neuron_read_valid    (neuron_read_valid),
    .clear_busy           (clear_busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: reset starts a clear of DEPTH cycles; when it ends the
  // whole array is zero. In IDLE the read sees the write of the same cycle
  // unless a clear request drops that write.
  always @(posedge clk) begin
    if (!rst_n) begin
      modelKnown <= 1'b1;
      mBusy      <= 1'b1;
      mLeft      <= DEPTH;
      mValid     <= 1'b0;
      mData      <= 8'h00;
    end else if (mBusy) begin
      mValid <= 1'b0;
      mLeft  <= mLeft - 1;
      if (mLeft == 1) begin
        mBusy <= 1'b0;
        for (int i = 0; i < DEPTH; i++) mMem[i] <= 8'h00;
      end
    end else begin
      mValid <= 1'b1;
      if (clear_request) begin
        mData <= mMem[neuron_read_address];
        mBusy <= 1'b1;
        mLeft <= DEPTH;
      end else begin
        if (neuron_write_enable) mMem[neuron_write_address] <= neuron_write_data;
        if (neuron_write_enable && neuron_write_address == neuron_read_address)
          mData <= neuron_write_data;
        else
          mData <= mMem[neuron_read_address];
      end
    end
  end

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  task automatic compareModel();
    if (modelKnown) begin
      checkOutput("model clear_busy", int'(clear_busy), int'(mBusy));
      checkOutput("model read_valid", int'(neuron_read_valid), int'(mValid));
      checkOutput("model read_data", int'(neuron_read_data), int'(mData));
    end
  endtask

  // Waits for the falling edge (outputs stable), compares, then drives the
  // inputs for the next rising edge.
  task automatic applyStimulus(input logic rstn, input logic req, input logic we,
                               input logic [7:0] waddr, input logic [7:0] wdata,
                               input logic [7:0] raddr);
    @(negedge clk);
    compareModel();
    rst_n                = rstn;
    clear_request        = req;
    neuron_write_enable  = we;
    neuron_write_address = waddr;
    neuron_write_data    = wdata;
    neuron_read_address  = raddr;
  endtask

  // Counts the cycles clear_busy is seen high starting now, optionally
  // pulsing clear_request on cycle pulseAt. Bounded so it cannot hang.
  task automatic waitClearDone(input int pulseAt, output int cycles);
    int cnt;
    cnt = 0;
    while (clear_busy && cnt < 1000) begin
      cnt++;
      applyStimulus(1'b1, (cnt == pulseAt), 1'b0, 8'h00, 8'h00, 8'h00);
    end
    cycles = cnt;
  endtask

  initial begin
    int n;
    checks               = 0;
    errors               = 0;
    modelKnown           = 1'b0;
    rst_n                = 1'b0;
    clear_request        = 1'b0;
    neuron_write_enable  = 1'b0;
    neuron_write_address = 8'h00;
    neuron_write_data    = 8'h00;
    neuron_read_address  = 8'h00;

    // Reset for two cycles, then release and time the clear.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("reset clear_busy", int'(clear_busy), 1);
    checkOutput("reset read_valid", int'(neuron_read_valid), 0);
    checkOutput("reset read_data", int'(neuron_read_data), 0);
    waitClearDone(0, n);
    checkOutput("reset clear length", n, 256);
    checkOutput("valid low as busy falls", int'(neuron_read_valid), 0);

    // Reads of cleared locations.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("first valid", int'(neuron_read_valid), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h7F);
    checkOutput("read 0x00", int'(neuron_read_data), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF);
    checkOutput("read 0x7F", int'(neuron_read_data), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("read 0xFF", int'(neuron_read_data), 0);
    checkOutput("read 0xFF valid", int'(neuron_read_valid), 1);

    // Write then read.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h10);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("write/read 0x10", int'(neuron_read_data), 8'hA5);

    // Same-cycle bypass, and a neighbouring read keeping its old value.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h21, 8'h99, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h20, 8'h3C, 8'h20);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("bypass 0x20", int'(neuron_read_data), 8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h20, 8'hC3, 8'h21);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h20);
    checkOutput("no bypass 0x21", int'(neuron_read_data), 8'h99);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("rewrite 0x20", int'(neuron_read_data), 8'hC3);

    // Write during clear request and during CLEAR is dropped.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h05, 8'h55, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h05);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("read 0x05 before clear", int'(neuron_read_data), 8'h55);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h05, 8'h77, 8'h05);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h05, 8'h77, 8'h00);
    checkOutput("clear start busy", int'(clear_busy), 1);
    checkOutput("clear start read valid", int'(neuron_read_valid), 1);
    checkOutput("clear start read data", int'(neuron_read_data), 8'h55);
    waitClearDone(0, n);
    checkOutput("request clear length", n, 256);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'(a));
      if (a > 0) checkOutput("sweep zero", int'(neuron_read_data), 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h05);
    checkOutput("sweep zero 0xFF", int'(neuron_read_data), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("0x05 after clear", int'(neuron_read_data), 0);

    // Clear re-request mid-clear is ignored.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h30, 8'hE7, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h30);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("rerequest start data", int'(neuron_read_data), 8'hE7);
    waitClearDone(100, n);
    checkOutput("rerequest clear length", n, 256);
    checkOutput("data held through clear", int'(neuron_read_data), 8'hE7);

    // Reset at cycle 50 of a clear restarts the sequence.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h30, 8'hE7, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h30);
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("mid-clear data before reset", int'(neuron_read_data), 8'hE7);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("mid-clear reset busy", int'(clear_busy), 1);
    checkOutput("mid-clear reset valid", int'(neuron_read_valid), 0);
    checkOutput("mid-clear reset data", int'(neuron_read_data), 0);
    waitClearDone(0, n);
    checkOutput("mid-clear reset length", n, 256);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h30);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("0x30 after reset clear", int'(neuron_read_data), 0);
    checkOutput("0x30 valid", int'(neuron_read_valid), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
